// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write scheduler: state encoding and default
// phase timings, all in clk cycles.
package lcd_pkg;

    typedef enum logic [2:0] {
        RSTP  = 3'd0,
        IDLE  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4
    } lcd_state_t;

    localparam int unsigned DEF_SETUP_CYC = 2;
    localparam int unsigned DEF_EN_CYC    = 4;
    localparam int unsigned DEF_HOLD_CYC  = 2;
    localparam int unsigned DEF_RST_CYC   = 8;

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin arbiter. The priority pointer names the requester that
// wins a tie; it moves to the other requester after every grant.
module lcd_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = req;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/lcd_write_sched.sv
// Schedules byte writes from two requesters onto a parallel LCD bus with
// programmable setup / enable / hold timing, after a panel reset pulse.
//
// state | meaning
// RSTP  | panel reset pulse (lcd_rst=1) after system reset
// IDLE  | bus quiet, arbiter may accept one write
// SETUP | db/rs driven, lcd_en low
// PULSE | db/rs driven, lcd_en high
// HOLD  | db/rs held after lcd_en falls
module lcd_write_sched
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned EN_CYC    = DEF_EN_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
    parameter int unsigned RST_CYC   = DEF_RST_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       busy,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_rst,
    output logic [7:0] lcd_db
);

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC);
    localparam logic [7:0] EN_LD    = 8'(EN_CYC);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC);
    localparam logic [7:0] RST_LD   = 8'(RST_CYC);

    lcd_state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [1:0] grant;
    logic       accept;
    logic       rs_q;
    logic [7:0] db_q;
    logic       in_write;

    lcd_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state == IDLE),
        .req   ({req1_valid, req0_valid}),
        .grant (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RSTP;
            cnt   <= RST_LD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Each timed state exits on the cycle its counter reads 1, so a reload
    // value of N yields exactly N cycles in that state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - 8'd1;
        accept    = 1'b0;
        case (state)
            RSTP: begin
                if (cnt == 8'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            IDLE: begin
                cnt_nxt = cnt;
                if (|grant) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == 8'd1) begin
                    state_nxt = PULSE;
                    cnt_nxt   = EN_LD;
                end
            end
            PULSE: begin
                if (cnt == 8'd1) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt == 8'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end
            end
            default: begin
                state_nxt = RSTP;
                cnt_nxt   = RST_LD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q <= 1'b0;
            db_q <= 8'h00;
        end else if (accept) begin
            rs_q <= grant[1] ? req1_rs   : req0_rs;
            db_q <= grant[1] ? req1_data : req0_data;
        end
    end

    // Bus outputs decode straight from state so an async reset clears them
    // without waiting for a clock edge.
    assign in_write   = (state == SETUP) || (state == PULSE) || (state == HOLD);
    assign lcd_db     = in_write ? db_q : 8'h00;
    assign lcd_rs     = in_write & rs_q;
    assign lcd_en     = (state == PULSE);
    assign lcd_rst    = (state == RSTP);
    assign lcd_rw     = 1'b0;
    assign busy       = (state != IDLE);
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

endmodule

// File: tb/tb_lcd_write_sched.sv
// Self-checking bench for lcd_write_sched: directed sequences, a vector
// table, and randomized traffic checked against a time-since-accept model.
module tb_lcd_write_sched;

    localparam int S = 2;
    localparam int E = 4;
    localparam int H = 2;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0, req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready, busy, lcd_en, lcd_rs, lcd_rw, lcd_rst;
    logic [7:0] lcd_db;

    logic       f_v0 = 1'b0, f_rs0 = 1'b0;
    logic [7:0] f_d0 = 8'h00;
    logic       f_r0, f_r1, f_busy, f_en, f_rs, f_rw, f_rst;
    logic [7:0] f_db;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    lcd_write_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .busy(busy), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_rst(lcd_rst), .lcd_db(lcd_db)
    );

    lcd_write_sched #(.SETUP_CYC(1), .EN_CYC(1), .HOLD_CYC(1), .RST_CYC(8)) dut_f (
        .clk(clk), .rst(rst),
        .req0_valid(f_v0), .req0_rs(f_rs0), .req0_data(f_d0), .req0_ready(f_r0),
        .req1_valid(1'b0), .req1_rs(1'b0), .req1_data(8'h00), .req1_ready(f_r1),
        .busy(f_busy), .lcd_en(f_en), .lcd_rs(f_rs), .lcd_rw(f_rw), .lcd_rst(f_rst), .lcd_db(f_db)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks cycles left in the panel reset and cycles since
    // the last accept; the bus picture follows from those two numbers.
    int   m_rst_left = R;
    int   m_k = 0;
    logic m_ptr = 1'b0;
    logic m_rs = 1'b0;
    logic [7:0] m_d = 8'h00;

    always @(negedge clk) begin
        logic e_r0, e_r1, e_busy, e_en, e_rs, e_rst;
        logic [7:0] e_db;
        int g;
        e_r0 = 1'b0; e_r1 = 1'b0; e_busy = 1'b0; e_en = 1'b0; e_rs = 1'b0; e_rst = 1'b0;
        e_db = 8'h00;
        g = -1;
        if (rst) begin
            e_rst = 1'b1; e_busy = 1'b1;
            m_rst_left = R; m_k = 0; m_ptr = 1'b0;
        end else if (m_rst_left > 0) begin
            e_rst = 1'b1; e_busy = 1'b1;
            m_rst_left--;
        end else if (m_k == 0) begin
            if (req0_valid && req1_valid) g = m_ptr ? 1 : 0;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
            if (g == 0) begin
                e_r0 = 1'b1; m_d = req0_data; m_rs = req0_rs;
            end
            if (g == 1) begin
                e_r1 = 1'b1; m_d = req1_data; m_rs = req1_rs;
            end
            if (g >= 0) begin
                m_k = 1;
                m_ptr = (g == 0);
            end
        end else begin
            e_busy = 1'b1; e_db = m_d; e_rs = m_rs;
            e_en = (m_k > S) && (m_k <= S + E);
            m_k = (m_k == S + E + H) ? 0 : m_k + 1;
        end
        chk("model", 32'({req0_ready, req1_ready, busy, lcd_en, lcd_rs, lcd_rst, lcd_rw, lcd_db}),
                     32'({e_r0, e_r1, e_busy, e_en, e_rs, e_rst, 1'b0, e_db}));
    end

    task automatic release_and_check_rstp();
        int n;
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lcd_rst) n++;
            else break;
        end
        chk("rstp_len", n, R);
        chk("idle_after_rstp", 32'(busy), 0);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == 50) chk("idle_timeout", 32'(busy), 0);
    endtask

    typedef struct {
        logic v0, v1, rs0, rs1;
        logic [7:0] d0, d1;
        logic [1:0] rdy;
        logic [7:0] db;
        logic rs;
    } vec_t;

    initial begin
        vec_t tbl[8];
        logic rd0, rd1;
        int n, last_c, en_cnt, found;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 2'b10, 8'h22, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 8'h5A, 2'b01, 8'hA5, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 2'b01, 8'h3C, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 2'b10, 8'hFF, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'b10, 8'h00, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 8'h7E, 2'b01, 8'h81, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h18, 2'b10, 8'h18, 1'b0};

        // Reset state and panel reset pulse length
        tick();
        chk("rst_lcd_rst", 32'(lcd_rst), 1);
        chk("rst_busy", 32'(busy), 1);
        chk("rst_db", 32'(lcd_db), 0);
        tick();
        release_and_check_rstp();

        // Single data write 0x37: one ready, 8 bus cycles, en on 3..6
        tick();
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h37;
        @(negedge clk);
        chk("w37_ready", 32'({req1_ready, req0_ready}), 'b01);
        tick();
        req0_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("w37_db", 32'(lcd_db), 'h37);
            chk("w37_rs", 32'(lcd_rs), 1);
            chk("w37_en", 32'(lcd_en), 32'(i >= 3 && i <= 6));
            chk("w37_noready", 32'(req0_ready), 0);
        end
        @(negedge clk);
        chk("w37_done_busy", 32'(busy), 0);
        chk("w37_done_db", 32'(lcd_db), 0);

        // Vector table of single accepts from IDLE
        for (int i = 0; i < 8; i++) begin
            wait_idle();
            tick();
            req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
            req0_rs = tbl[i].rs0; req1_rs = tbl[i].rs1;
            req0_data = tbl[i].d0; req1_data = tbl[i].d1;
            @(negedge clk);
            chk("tbl_ready", 32'({req1_ready, req0_ready}), 32'(tbl[i].rdy));
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
            chk("tbl_busy", 32'(busy), 32'(tbl[i].rdy != 2'b00));
            chk("tbl_db", 32'(lcd_db), 32'(tbl[i].db));
            chk("tbl_rs", 32'(lcd_rs), 32'(tbl[i].rs));
        end

        // Both held valid: grants alternate 0,1,0,1, nine cycles apart
        wait_idle();
        tick();
        req0_valid = 1'b1; req0_data = 8'h10; req0_rs = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h20; req1_rs = 1'b1;
        last_c = 0;
        for (int w = 0; w < 4; w++) begin
            found = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    found = 1;
                    break;
                end
            end
            chk("rr_found", found, 1);
            chk("rr_order", 32'(req1_ready), w % 2);
            chk("rr_onehot", 32'(req0_ready & req1_ready), 0);
            if (w > 0) chk("rr_spacing", cyc - last_c, 1 + S + E + H);
            last_c = cyc;
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Request raised mid-write waits for IDLE, then is taken immediately
        wait_idle();
        tick();
        req0_valid = 1'b1; req0_data = 8'h55; req0_rs = 1'b0;
        @(negedge clk);
        chk("late_first_ready", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h99; req1_rs = 1'b1;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!busy) break;
            chk("late_no_ready", 32'(req1_ready), 0);
            n++;
        end
        chk("late_busy_len", n, S + E + H);
        chk("late_accept", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;

        // Reset during PULSE clears the bus asynchronously and restarts RSTP
        wait_idle();
        tick();
        req0_valid = 1'b1; req0_data = 8'hE7; req0_rs = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lcd_en) break;
        end
        chk("abort_in_pulse", 32'(lcd_en), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_en", 32'(lcd_en), 0);
        chk("abort_db", 32'(lcd_db), 0);
        chk("abort_lcd_rst", 32'(lcd_rst), 1);
        tick();
        tick();
        release_and_check_rstp();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_no_retry", 32'(lcd_en), 0);
        end

        // Randomized traffic with occasional resets, checked by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rd0 = req0_ready;
            rd1 = req1_ready;
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            if (rd0) req0_valid = 1'b0;
            if (rd1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1; req0_rs = 1'($urandom); req0_data = 8'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1; req1_rs = 1'($urandom); req1_data = 8'($urandom);
            end
        end
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Minimum timings: 4-cycle writes with a single-cycle enable
        tick();
        f_v0 = 1'b1; f_d0 = 8'hC4; f_rs0 = 1'b0;
        last_c = 0;
        for (int w = 0; w < 3; w++) begin
            found = 0;
            en_cnt = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (f_en) begin
                    en_cnt++;
                    chk("fast_db", 32'(f_db), 'hC4);
                end
                if (f_r0) begin
                    found = 1;
                    break;
                end
            end
            chk("fast_found", found, 1);
            if (w > 0) begin
                chk("fast_spacing", cyc - last_c, 4);
                chk("fast_en_width", en_cnt, 1);
            end
            last_c = cyc;
        end
        tick();
        f_v0 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
